// File: rtl/riscv_pkg.sv
// Shared encodings for the minimal RV32I core: opcodes, sequencer states,
// datapath mux selects and the decoded instruction class.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_JALR  = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_e;

   typedef enum logic [3:0] {
      CLS_LUI    = 4'd0,
      CLS_AUIPC  = 4'd1,
      CLS_JAL    = 4'd2,
      CLS_JALR   = 4'd3,
      CLS_BRANCH = 4'd4,
      CLS_LOAD   = 4'd5,
      CLS_STORE  = 4'd6,
      CLS_OPIMM  = 4'd7,
      CLS_OP     = 4'd8
   } iclass_e;

   // Immediate format used for the ALU operand / address of each class.
   function automatic imm_sel_e class_imm(input iclass_e cls);
      case (cls)
         CLS_LUI, CLS_AUIPC: return IMM_U;
         CLS_JAL:            return IMM_J;
         CLS_BRANCH:         return IMM_B;
         CLS_STORE:          return IMM_S;
         default:            return IMM_I;
      endcase
   endfunction

   // Branches compare rs1/rs2 and OP is register-register; all else takes the immediate.
   function automatic logic class_uses_imm(input iclass_e cls);
      return !(cls == CLS_BRANCH || cls == CLS_OP);
   endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode/funct3 classifier; flags encodings the core does not implement.
module op_classify
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   output iclass_e    class_o,
   output logic       legal_o
);

   always_comb begin
      class_o = CLS_LUI;
      legal_o = 1'b0;
      case (opcode_i)
         OPC_LUI:    begin class_o = CLS_LUI;    legal_o = 1'b1; end
         OPC_AUIPC:  begin class_o = CLS_AUIPC;  legal_o = 1'b1; end
         OPC_JAL:    begin class_o = CLS_JAL;    legal_o = 1'b1; end
         OPC_JALR:   begin class_o = CLS_JALR;   legal_o = (funct3_i == 3'd0); end
         OPC_BRANCH: begin
            class_o = CLS_BRANCH;
            legal_o = (funct3_i != 3'd2) && (funct3_i != 3'd3);
         end
         OPC_LOAD: begin
            class_o = CLS_LOAD;
            legal_o = (funct3_i != 3'd3) && (funct3_i != 3'd6) && (funct3_i != 3'd7);
         end
         OPC_STORE:  begin class_o = CLS_STORE;  legal_o = (funct3_i <= 3'd2); end
         OPC_OPIMM:  begin class_o = CLS_OPIMM;  legal_o = 1'b1; end
         OPC_OP:     begin class_o = CLS_OP;     legal_o = 1'b1; end
         default:    begin class_o = CLS_LUI;    legal_o = 1'b0; end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core,
// with halt on unsupported encodings and a retired-instruction counter.
module control_sequencer
   import riscv_pkg::*;
#(
   parameter state_e RESET_STATE = ST_FETCH
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        ir_load,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   input  logic        branch_taken,
   output logic        alu_src_b,
   output logic [2:0]  imm_sel,
   output logic        pc_load,
   output logic [1:0]  pc_sel,
   output logic        rf_write,
   output logic [1:0]  wb_sel,
   output logic        halted,
   output logic [2:0]  state,
   output logic [31:0] retired_count
);

   state_e      state_q, state_d;
   iclass_e     cls_q, cls_d;
   logic [31:0] retired_q;
   logic        retire;

   iclass_e     dec_cls;
   logic        dec_legal;

   logic        imem_req_c, ir_load_c, dmem_req_c, dmem_we_c, alu_src_b_c;
   logic        pc_load_c, rf_write_c, halted_c;
   imm_sel_e    imm_sel_c;
   pc_sel_e     pc_sel_c;
   wb_sel_e     wb_sel_c;

   op_classify u_op_classify (
      .opcode_i (opcode),
      .funct3_i (funct3),
      .class_o  (dec_cls),
      .legal_o  (dec_legal)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= RESET_STATE;
         cls_q     <= CLS_LUI;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      retire      = 1'b0;
      imem_req_c  = 1'b0;
      ir_load_c   = 1'b0;
      dmem_req_c  = 1'b0;
      dmem_we_c   = 1'b0;
      alu_src_b_c = 1'b0;
      imm_sel_c   = IMM_I;
      pc_load_c   = 1'b0;
      pc_sel_c    = PC_PLUS4;
      rf_write_c  = 1'b0;
      wb_sel_c    = WB_ALU;
      halted_c    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ready) begin
               ir_load_c = 1'b1;
               state_d   = ST_DECODE;
            end
         end
         ST_DECODE: begin
            cls_d   = dec_cls;
            state_d = dec_legal ? ST_EXECUTE : ST_HALT;
         end
         ST_EXECUTE: begin
            alu_src_b_c = class_uses_imm(cls_q);
            imm_sel_c   = class_imm(cls_q);
            case (cls_q)
               CLS_BRANCH: begin
                  pc_load_c = 1'b1;
                  pc_sel_c  = branch_taken ? PC_IMM : PC_PLUS4;
                  retire    = 1'b1;
                  state_d   = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
               default:             state_d = ST_WRITEBACK;
            endcase
         end
         ST_MEMORY: begin
            // Address operands stay selected for the whole access, including wait cycles.
            dmem_req_c  = 1'b1;
            dmem_we_c   = (cls_q == CLS_STORE);
            alu_src_b_c = class_uses_imm(cls_q);
            imm_sel_c   = class_imm(cls_q);
            if (dmem_ready) begin
               if (cls_q == CLS_STORE) begin
                  pc_load_c = 1'b1;
                  retire    = 1'b1;
                  state_d   = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end
         end
         ST_WRITEBACK: begin
            rf_write_c = 1'b1;
            pc_load_c  = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
            case (cls_q)
               CLS_LOAD: wb_sel_c = WB_LOAD;
               CLS_JAL:  begin wb_sel_c = WB_PC4; pc_sel_c = PC_IMM;  end
               CLS_JALR: begin wb_sel_c = WB_PC4; pc_sel_c = PC_JALR; end
               default:  wb_sel_c = WB_ALU;
            endcase
         end
         ST_HALT: halted_c = 1'b1;
         default: state_d = RESET_STATE;
      endcase
   end

   // Reset forces every output low at once, abandoning any pending memory request.
   assign imem_req      = reset_n & imem_req_c;
   assign ir_load       = reset_n & ir_load_c;
   assign dmem_req      = reset_n & dmem_req_c;
   assign dmem_we       = reset_n & dmem_we_c;
   assign alu_src_b     = reset_n & alu_src_b_c;
   assign imm_sel       = reset_n ? imm_sel_c : 3'd0;
   assign pc_load       = reset_n & pc_load_c;
   assign pc_sel        = reset_n ? pc_sel_c : 2'd0;
   assign rf_write      = reset_n & rf_write_c;
   assign wb_sel        = reset_n ? wb_sel_c : 2'd0;
   assign halted        = reset_n & halted_c;
   assign state         = reset_n ? state_q : 3'd0;
   assign retired_count = reset_n ? retired_q : 32'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected output vectors are
// queued with their stimulus, then popped and compared cycle by cycle.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        imem_req, imem_ready, ir_load;
   logic        dmem_req, dmem_we, dmem_ready, branch_taken;
   logic        alu_src_b, pc_load, rf_write, halted;
   logic [2:0]  imm_sel, state;
   logic [1:0]  pc_sel, wb_sel;
   logic [31:0] retired_count;

   logic [31:0] fetch_word;
   logic [31:0] ir_q = 32'h0;

   typedef logic [17:0] ovec_t;
   typedef logic [34:0] stim_t;   // {fetch_word, imem_ready, dmem_ready, branch_taken}

   ovec_t       obs;
   ovec_t       exp_q[$];
   stim_t       stim_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_ret = 0;

   always #5 clock = ~clock;

   always @(posedge clock) if (ir_load) ir_q <= fetch_word;
   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];

   assign obs = {imem_req, ir_load, dmem_req, dmem_we, alu_src_b, imm_sel,
                 pc_load, pc_sel, rf_write, wb_sel, halted, state};

   control_sequencer dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_load(ir_load),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .branch_taken(branch_taken), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
      .pc_load(pc_load), .pc_sel(pc_sel), .rf_write(rf_write), .wb_sel(wb_sel),
      .halted(halted), .state(state), .retired_count(retired_count)
   );

   function automatic ovec_t ov(input logic [2:0] st, input logic ireq, input logic irl,
                                input logic dreq, input logic dwe, input logic asb,
                                input logic [2:0] imm, input logic pcl, input logic [1:0] pcs,
                                input logic rfw, input logic [1:0] wbs, input logic hlt);
      return {ireq, irl, dreq, dwe, asb, imm, pcl, pcs, rfw, wbs, hlt, st};
   endfunction

   function automatic ovec_t f_rdy();  return ov(0,1,1,0,0,0,0,0,0,0,0,0); endfunction
   function automatic ovec_t f_wait(); return ov(0,1,0,0,0,0,0,0,0,0,0,0); endfunction
   function automatic ovec_t dec();    return ov(1,0,0,0,0,0,0,0,0,0,0,0); endfunction

   task automatic push(input logic [31:0] w, input logic ir, input logic dr, input logic bt,
                       input ovec_t e);
      stim_q.push_back({w, ir, dr, bt});
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      exp_ret = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
      fetch_word = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock); #1;
      n_checks++;
      if (obs !== 18'h0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0);
      end
      n_checks++;
      if (retired_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired_count);
      end
      @(negedge clock);
      reset_n = 1'b1; #1;
      n_checks++;
      if (obs !== f_wait()) begin
         n_fail++; $display("FAIL reset_release_fetch: got %h expected %h", obs, f_wait());
      end
      exp_ret = 0;
   endtask

   task automatic test_addi();
      int cyc = 0;
      push(32'h00500093, 1, 0, 0, f_rdy());
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,0,1,0,0));
      exp_ret += 1;
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL addi cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); imem_ready = 1'b0; #1; n_checks++;
      if (retired_count !== exp_ret) begin
         n_fail++; $display("FAIL addi_retired: got %0d expected %0d", retired_count, exp_ret);
      end
   endtask

   task automatic test_fetch_wait();
      int cyc = 0;
      for (int i = 0; i < 3; i++) push(32'h002081B3, 0, 0, 0, f_wait());
      push(32'h002081B3, 1, 0, 0, f_rdy());
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,0,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,0,1,0,0));
      exp_ret += 1;
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL fetch_wait cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); imem_ready = 1'b0; #1; n_checks++;
      if (retired_count !== exp_ret) begin
         n_fail++; $display("FAIL fetch_wait_retired: got %0d expected %0d", retired_count, exp_ret);
      end
   endtask

   task automatic test_load_wait();
      int cyc = 0;
      push(32'h0000A103, 1, 0, 0, f_rdy());
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(3,0,0,1,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(3,0,0,1,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 1, 0, ov(3,0,0,1,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,0,1,1,0));
      exp_ret += 1;
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL load cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); imem_ready = 1'b0; dmem_ready = 1'b0; #1; n_checks++;
      if (retired_count !== exp_ret || state !== 3'd0) begin
         n_fail++; $display("FAIL load_retired: got %0d/state %0d expected %0d/state 0",
                            retired_count, state, exp_ret);
      end
   endtask

   task automatic test_branch();
      int cyc = 0;
      push(32'h00000463, 1, 0, 0, f_rdy());
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 1, ov(2,0,0,0,0,0,2,1,1,0,0,0));
      // Not-taken: branch_taken is high outside EXECUTE and must be ignored there.
      push(32'h00000463, 1, 0, 1, f_rdy());
      push(32'h0, 0, 0, 1, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,0,2,1,0,0,0,0));
      exp_ret += 2;
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL branch cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); imem_ready = 1'b0; branch_taken = 1'b0; #1; n_checks++;
      if (retired_count !== exp_ret) begin
         n_fail++; $display("FAIL branch_retired: got %0d expected %0d", retired_count, exp_ret);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      push(32'h0020A023, 1, 0, 0, f_rdy());                      // SW
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,1,0,0,0,0,0));
      push(32'h0, 0, 1, 0, ov(3,0,0,1,1,1,1,1,0,0,0,0));
      push(32'h0000006F, 1, 0, 0, f_rdy());                      // JAL
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,4,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,1,1,2,0));
      push(32'h00008067, 1, 0, 0, f_rdy());                      // JALR
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,0,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,2,1,2,0));
      push(32'h000010B7, 1, 0, 0, f_rdy());                      // LUI
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,3,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(4,0,0,0,0,0,0,1,0,1,0,0));
      exp_ret += 4;
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL back_to_back cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); imem_ready = 1'b0; dmem_ready = 1'b0; #1; n_checks++;
      if (retired_count !== exp_ret) begin
         n_fail++; $display("FAIL back_to_back_retired: got %0d expected %0d", retired_count, exp_ret);
      end
   endtask

   task automatic test_reset_mid_store();
      int cyc = 0;
      push(32'h0020A023, 1, 0, 0, f_rdy());
      push(32'h0, 0, 0, 0, dec());
      push(32'h0, 0, 0, 0, ov(2,0,0,0,0,1,1,0,0,0,0,0));
      push(32'h0, 0, 0, 0, ov(3,0,0,1,1,1,1,0,0,0,0,0));
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL mid_store cyc%0d: got %h expected %h", cyc, obs, e);
         end
      end
      @(negedge clock); reset_n = 1'b0; #1; n_checks++;
      if (obs !== 18'h0 || dmem_req !== 1'b0) begin
         n_fail++; $display("FAIL mid_store_reset_drop: got %h expected %h", obs, 18'h0);
      end
      @(negedge clock); reset_n = 1'b1; #1; exp_ret = 0; n_checks++;
      if (obs !== f_wait()) begin
         n_fail++; $display("FAIL mid_store_release: got %h expected %h", obs, f_wait());
      end
      n_checks++;
      if (retired_count !== 32'd0) begin
         n_fail++; $display("FAIL mid_store_retired: got %0d expected 0", retired_count);
      end
   endtask

   task automatic test_halt(input logic [31:0] word);
      int cyc = 0;
      push(word, 1, 0, 0, f_rdy());
      push(32'h0, 1, 0, 0, dec());
      for (int i = 0; i < 20; i++) push(32'h0, 1, 1, 1, ov(5,0,0,0,0,0,0,0,0,0,0,1));
      while (exp_q.size() > 0) begin
         ovec_t e;
         @(negedge clock);
         {fetch_word, imem_ready, dmem_ready, branch_taken} = stim_q.pop_front();
         #1; e = exp_q.pop_front(); cyc++; n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL halt_%h cyc%0d: got %h expected %h", word, cyc, obs, e);
         end
      end
      n_checks++;
      if (retired_count !== exp_ret) begin
         n_fail++; $display("FAIL halt_%h_retired: got %0d expected %0d", word, retired_count, exp_ret);
      end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_fetch_wait();
      test_load_wait();
      test_branch();
      test_back_to_back();
      test_reset_mid_store();
      test_addi();
      test_halt(32'h0000007F);
      test_halt(32'h00003003);
      test_addi();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
